// File: rtl/approx_mult_4x4_pkg.sv
// Shared widths, types and partial-product helpers for the 4x4 approximate multiplier.
// Column k of the partial-product array holds every pp[i][j] with i + j == k.
package approx_mult_4x4_pkg;

  localparam int OPW                 = 4;
  localparam int PW                  = 2 * OPW;
  localparam int DEFAULT_APPROX_COLS = 3;

  typedef logic [OPW-1:0]            opnd_t;
  typedef logic [PW-1:0]             prod_t;
  // pp[i][j] = A[j] & B[i]
  typedef logic [OPW-1:0][OPW-1:0]   pp_t;

  function automatic int col_of(input int i, input int j);
    return i + j;
  endfunction

endpackage

// File: rtl/approx_col_or.sv
// OR-reduction of the low partial-product columns: one output bit per column,
// carries inside these columns are deliberately discarded.
module approx_col_or
  import approx_mult_4x4_pkg::*;
#(
  parameter int APPROX_COLS = DEFAULT_APPROX_COLS
) (
  input  pp_t                    pp_i,
  output logic [APPROX_COLS-1:0] col_o
);

  for (genvar k = 0; k < APPROX_COLS; k++) begin : g_col
    logic col_bit;

    // NOTE: give every always_comb variable a default before any conditional write, or a latch is inferred.
    always_comb begin
      col_bit = 1'b0;
      for (int i = 0; i < OPW; i++) begin
        for (int j = 0; j < OPW; j++) begin
          if (col_of(i, j) == k) col_bit = col_bit | pp_i[i][j];
        end
      end
    end

    assign col_o[k] = col_bit;
  end

  // High-column partial products are summed in the top; tie them off here.
  logic unused_pp;
  assign unused_pp = ^pp_i;

endmodule

// File: rtl/approx_mult_4x4.sv
// Unsigned 4x4 approximate multiplier: low columns OR-reduced, high columns summed exactly.
// P is combinational; P_q is P registered with an asynchronous active-low clear.
module approx_mult_4x4
  import approx_mult_4x4_pkg::*;
#(
  parameter int APPROX_COLS = DEFAULT_APPROX_COLS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  output logic [PW-1:0]  P,
  output logic [PW-1:0]  P_q
);

  localparam int HW = PW - APPROX_COLS;

  pp_t                    pp;
  logic [APPROX_COLS-1:0] low_cols;
  logic [HW-1:0]          high_d;
  prod_t                  p_d;

  always_comb begin
    pp = '0;
    for (int i = 0; i < OPW; i++) begin
      for (int j = 0; j < OPW; j++) begin
        pp[i][j] = A[j] & B[i];
      end
    end
  end

  approx_col_or #(
    .APPROX_COLS (APPROX_COLS)
  ) u_col_or (
    .pp_i  (pp),
    .col_o (low_cols)
  );

  // Exact sum of the upper columns, rebased so column APPROX_COLS has weight 1; it cannot overflow HW bits.
  always_comb begin
    high_d = '0;
    for (int i = 0; i < OPW; i++) begin
      for (int j = 0; j < OPW; j++) begin
        if (col_of(i, j) >= APPROX_COLS)
          high_d = high_d + (HW'(pp[i][j]) << (col_of(i, j) - APPROX_COLS));
      end
    end
  end

  assign p_d = {high_d, low_cols};
  assign P   = p_d;

  // NOTE: sequential state uses non-blocking assignments; the asynchronous clear sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) P_q <= '0;
    else        P_q <= p_d;
  end

endmodule

// File: tb/tb_approx_mult_4x4.sv
// Self-checking bench for approx_mult_4x4: directed, exhaustive and random vectors
// against an arithmetic reference model, plus registered-path and async-reset checks.
module tb_approx_mult_4x4;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic [7:0] P_q;
  logic [7:0] P1;
  logic [7:0] P1_q;

  int n_vec;
  int n_err;
  int exp_v;
  int ra;
  int rb;
  int nz_cnt;
  real rel_sum;

  int dir_a [7] = '{15, 3, 7, 4, 0, 9, 2};
  int dir_b [7] = '{15, 3, 1, 4, 9, 0, 3};
  int dir_p [7] = '{215, 7, 7, 16, 0, 0, 6};

  approx_mult_4x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P     (P),
    .P_q   (P_q)
  );

  approx_mult_4x4 #(.APPROX_COLS(1)) dut_exact (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .P     (P1),
    .P_q   (P1_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product, minus the true contribution of each low column,
  // plus that column's weight once if any of its partial products is set.
  function automatic int model_p(input int a, input int b, input int k);
    int result;
    result = a * b;
    for (int col = 0; col < k; col++) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (i + j == col && ((a >> j) & 1) == 1 && ((b >> i) & 1) == 1) cnt++;
      result = result - (cnt << col);
      if (cnt > 0) result = result + (1 << col);
    end
    return result;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    nz_cnt  = 0;
    rel_sum = 0.0;
    rst_n   = 1'b0;
    A       = 4'd0;
    B       = 4'd0;

    #2;
    check("reset_pq", 16'(P_q), 16'd0);
    @(posedge clk); #1;
    check("reset_hold_pq", 16'(P_q), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      A = 4'(dir_a[n]);
      B = 4'(dir_b[n]);
      #1;
      check($sformatf("dir_p a=%0d b=%0d", dir_a[n], dir_b[n]), 16'(P), 16'(dir_p[n]));
      check($sformatf("dir_exact a=%0d b=%0d", dir_a[n], dir_b[n]), 16'(P1), 16'(dir_a[n] * dir_b[n]));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a);
        B = 4'(b);
        #1;
        check($sformatf("exh_p a=%0d b=%0d", a, b), 16'(P), 16'(model_p(a, b, 3)));
        check($sformatf("exh_le a=%0d b=%0d", a, b), 16'(int'(P) <= a * b), 16'd1);
        check($sformatf("exh_zero a=%0d b=%0d", a, b), 16'(P == 8'd0), 16'(a == 0 || b == 0));
        check($sformatf("exh_k1 a=%0d b=%0d", a, b), 16'(P1), 16'(a * b));
        if (a * b != 0) begin
          nz_cnt++;
          rel_sum = rel_sum + real'(a * b - int'(P)) / real'(a * b);
        end
      end
    end
    $display("mean relative error over %0d nonzero products: %f", nz_cnt, rel_sum / real'(nz_cnt));

    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    @(posedge clk); #1;
    check("reg_pq_215", 16'(P_q), 16'd215);
    A = 4'd1;
    B = 4'd1;
    #1;
    check("reg_p_now_1", 16'(P), 16'd1);
    check("reg_pq_holds", 16'(P_q), 16'd215);
    @(posedge clk); #1;
    check("reg_pq_1", 16'(P_q), 16'd1);

    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      A  = 4'(ra);
      B  = 4'(rb);
      #1;
      check($sformatf("rnd_p a=%0d b=%0d", ra, rb), 16'(P), 16'(model_p(ra, rb, 3)));
      @(posedge clk); #1;
      check($sformatf("rnd_pq a=%0d b=%0d", ra, rb), 16'(P_q), 16'(model_p(ra, rb, 3)));
      check($sformatf("rnd_k1_pq a=%0d b=%0d", ra, rb), 16'(P1_q), 16'(ra * rb));
    end

    @(negedge clk);
    A = 4'd5;
    B = 4'd6;
    @(posedge clk); #1;
    check("rst_pre_pq", 16'(P_q), 16'(model_p(5, 6, 3)));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_pq", 16'(P_q), 16'd0);
    A = 4'd15;
    B = 4'd15;
    #1;
    check("rst_p_tracks", 16'(P), 16'd215);
    check("rst_pq_still0", 16'(P_q), 16'd0);
    @(posedge clk); #1;
    check("rst_held_edge_pq", 16'(P_q), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 4'd11;
    B = 4'd13;
    #1;
    check("rst_release_noedge_pq", 16'(P_q), 16'd0);
    @(posedge clk); #1;
    check("rst_release_load_pq", 16'(P_q), 16'(model_p(11, 13, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
